// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot sequencer: packet/store formats, boot states and default constants.
package boot_loader_pkg;

  localparam int rs_imm_size_gp = 6;

  localparam logic [9:0]  boot_core_id_c   = 10'd1;
  localparam logic [9:0]  boot_bar_addr_c  = 10'd24;
  localparam logic [31:0] boot_bar_mask_c  = 32'h2;
  localparam logic [31:0] boot_start_pc_c  = 32'h5;
  localparam logic [31:0] boot_done_data_c = 32'hFFFF_FFFE;

  typedef enum logic [2:0] {
    NET_OP_NULL  = 3'd0,
    NET_OP_INSTR = 3'd1,
    NET_OP_REG   = 3'd2,
    NET_OP_PC    = 3'd3,
    NET_OP_BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  id;
    net_op_e     net_op;
    logic [2:0]  reserved;
    logic [9:0]  net_addr;
    logic [31:0] net_data;
  } net_packet_s;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_DATA,
    BOOT_INSTR,
    BOOT_REG,
    BOOT_BAR,
    BOOT_PC,
    BOOT_DONE
  } boot_state_e;

  // A single-entry ROM still needs a one-bit address bus.
  function automatic int addr_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// ROM read bus between the boot sequencer (master) and the instruction/data/register ROMs (slave).
interface boot_loader_if #(
  parameter int instr_count_p = 1024,
  parameter int data_count_p  = 1024,
  parameter int reg_count_p   = 2 ** boot_loader_pkg::rs_imm_size_gp
);

  localparam int instr_aw_lp = boot_loader_pkg::addr_width(instr_count_p);
  localparam int data_aw_lp  = boot_loader_pkg::addr_width(data_count_p);
  localparam int reg_aw_lp   = boot_loader_pkg::addr_width(reg_count_p);

  logic [instr_aw_lp-1:0] instr_rom_addr_o;
  logic [15:0]            instr_rom_data_i;
  logic [data_aw_lp-1:0]  data_rom_addr_o;
  logic [31:0]            data_rom_data_i;
  logic [reg_aw_lp-1:0]   reg_rom_addr_o;
  logic [39:0]            reg_rom_data_i;

  modport master (
    output instr_rom_addr_o, data_rom_addr_o, reg_rom_addr_o,
    input  instr_rom_data_i, data_rom_data_i, reg_rom_data_i
  );

  modport slave (
    input  instr_rom_addr_o, data_rom_addr_o, reg_rom_addr_o,
    output instr_rom_data_i, data_rom_data_i, reg_rom_data_i
  );

endinterface

// File: rtl/boot_loader_rom_sequencer.sv
// Walks a ROM from address 0 to count_p-1 while enabled and flags, one cycle later, which address's data is on the ROM output.
module boot_rom_sequencer
  import boot_loader_pkg::*;
#(
  parameter int count_p = 4,
  localparam int aw_lp = addr_width(count_p)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [aw_lp-1:0] addr,
  output logic [aw_lp-1:0] addr_d,
  output logic             valid,
  output logic             last
);

  localparam logic [aw_lp-1:0] last_addr_lp = aw_lp'(count_p - 1);

  logic issued;

  // Dropping enable rewinds the walker so the next phase starts from address 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr   <= '0;
      addr_d <= '0;
      valid  <= 1'b0;
      issued <= 1'b0;
    end else if (!enable) begin
      addr   <= '0;
      addr_d <= '0;
      valid  <= 1'b0;
      issued <= 1'b0;
    end else begin
      valid  <= !issued;
      addr_d <= addr;
      if (addr == last_addr_lp) begin
        issued <= 1'b1;
      end else begin
        addr <= addr + aw_lp'(1);
      end
    end
  end

  assign last = valid && (addr_d == last_addr_lp);

endmodule

// File: rtl/boot_loader.sv
// Boot sequencer: data-ROM stores, then INSTR/REG/BAR/PC packets, then hands data memory to the core.
// Optional BOOT_LOADER_CHECKSUM_EN adds checksum_o, a running sum of every stored word and INSTR/REG payload.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int          instr_count_p = 1024,
  parameter int          data_count_p  = 1024,
  parameter int          reg_count_p   = 2 ** rs_imm_size_gp,
  parameter logic [9:0]  core_id_p     = boot_core_id_c,
  parameter logic [9:0]  bar_addr_p    = boot_bar_addr_c,
  parameter logic [31:0] bar_mask_p    = boot_bar_mask_c,
  parameter logic [31:0] start_pc_p    = boot_start_pc_c
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_i,
  boot_loader_if.master                   rom,
  output logic [$bits(net_packet_s)-1:0]  net_packet_flat_o,
  output logic [$bits(mem_in_s)-1:0]      to_mem_flat_o,
  output logic [31:0]                     data_mem_addr_o,
  output logic                            mem_select_o,
  output logic                            busy_o,
  output logic                            done_o
`ifdef BOOT_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]                     checksum_o
`endif
);

  localparam int data_aw_lp  = addr_width(data_count_p);
  localparam int instr_aw_lp = addr_width(instr_count_p);
  localparam int reg_aw_lp   = addr_width(reg_count_p);
  localparam logic [data_aw_lp-1:0] data_last_lp = data_aw_lp'(data_count_p - 1);

  if (instr_count_p < 1 || data_count_p < 1 || reg_count_p < 1) begin : g_bad_count
    $error("boot_loader: instr/data/reg counts must all be at least 1");
  end

  boot_state_e           state;
  logic [data_aw_lp-1:0] data_addr;
  logic                  data_b;
  net_packet_s           pkt_q;
  net_packet_s           packet;
  mem_in_s               to_mem;

  logic                   instr_valid;
  logic                   instr_last;
  logic [instr_aw_lp-1:0] instr_addr;
  logic [instr_aw_lp-1:0] instr_addr_d;
  logic                   reg_valid;
  logic                   reg_last;
  logic [reg_aw_lp-1:0]   reg_addr;
  logic [reg_aw_lp-1:0]   unused_reg_addr_d;
  logic [1:0]             unused_reg_bits;

  boot_rom_sequencer #(.count_p(instr_count_p)) u_instr_seq (
    .clk    (clk),
    .reset  (reset),
    .enable (state == BOOT_INSTR),
    .addr   (instr_addr),
    .addr_d (instr_addr_d),
    .valid  (instr_valid),
    .last   (instr_last)
  );

  boot_rom_sequencer #(.count_p(reg_count_p)) u_reg_seq (
    .clk    (clk),
    .reset  (reset),
    .enable (state == BOOT_REG),
    .addr   (reg_addr),
    .addr_d (unused_reg_addr_d),
    .valid  (reg_valid),
    .last   (reg_last)
  );

  assign rom.instr_rom_addr_o = instr_addr;
  assign rom.reg_rom_addr_o   = reg_addr;
  assign rom.data_rom_addr_o  = data_addr;
  assign unused_reg_bits      = rom.reg_rom_data_i[39:38];

  // Phase control plus the fixed BAR/PC/DONE packets; DATA alternates address (A) and store (B) cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT_IDLE;
      data_addr    <= '0;
      data_b       <= 1'b0;
      pkt_q        <= '0;
      mem_select_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        BOOT_IDLE: begin
          if (start_i) begin
            state  <= BOOT_DATA;
            busy_o <= 1'b1;
          end
        end
        BOOT_DATA: begin
          if (!data_b) begin
            data_b <= 1'b1;
          end else begin
            data_b <= 1'b0;
            if (data_addr == data_last_lp) begin
              data_addr <= '0;
              state     <= BOOT_INSTR;
            end else begin
              data_addr <= data_addr + data_aw_lp'(1);
            end
          end
        end
        BOOT_INSTR: begin
          if (instr_last) state <= BOOT_REG;
        end
        BOOT_REG: begin
          if (reg_last) begin
            state <= BOOT_BAR;
            pkt_q <= '{id: core_id_p, net_op: NET_OP_BAR, reserved: '0,
                       net_addr: bar_addr_p, net_data: bar_mask_p};
          end
        end
        BOOT_BAR: begin
          state <= BOOT_PC;
          pkt_q <= '{id: core_id_p, net_op: NET_OP_PC, reserved: '0,
                     net_addr: '0, net_data: start_pc_p};
        end
        BOOT_PC: begin
          state        <= BOOT_DONE;
          pkt_q        <= '{id: core_id_p, net_op: NET_OP_NULL, reserved: '0,
                            net_addr: bar_addr_p, net_data: boot_done_data_c};
          mem_select_o <= 1'b1;
          busy_o       <= 1'b0;
          done_o       <= 1'b1;
        end
        BOOT_DONE: begin
        end
        default: state <= BOOT_IDLE;
      endcase
    end
  end

  // ROM payloads come straight off the synchronous ROM outputs so each word lands in the cycle after its address.
  always_comb begin
    packet = pkt_q;
    if (instr_valid) begin
      packet = '{id: core_id_p, net_op: NET_OP_INSTR, reserved: '0,
                 net_addr: 10'(instr_addr_d), net_data: {16'b0, rom.instr_rom_data_i}};
    end else if (reg_valid) begin
      packet = '{id: core_id_p, net_op: NET_OP_REG, reserved: '0,
                 net_addr: {4'b0, rom.reg_rom_data_i[37:32]}, net_data: rom.reg_rom_data_i[31:0]};
    end
  end

  always_comb begin
    to_mem = '0;
    if (data_b) begin
      to_mem.valid      = 1'b1;
      to_mem.wen        = 1'b1;
      to_mem.yumi       = 1'b1;
      to_mem.write_data = rom.data_rom_data_i;
    end
  end

  assign net_packet_flat_o = packet;
  assign to_mem_flat_o     = to_mem;
  assign data_mem_addr_o   = data_b ? (32'(data_addr) << 2) : 32'h0;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] checksum_add;

  always_comb begin
    checksum_add = '0;
    if (data_b) begin
      checksum_add = rom.data_rom_data_i;
    end else if (instr_valid || reg_valid) begin
      checksum_add = packet.net_data;
    end
  end

  // Sum of everything loaded, frozen once the core owns memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_o <= '0;
    end else if (state != BOOT_DONE) begin
      checksum_o <= checksum_o + checksum_add;
    end
  end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader with 4-entry ROMs: stimulus queues expected events, a negedge monitor pops and compares.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int N = 4;

  typedef enum int {EV_STORE = 1, EV_PKT = 2, EV_DONE = 3} ev_kind_e;

  typedef struct {
    ev_kind_e     kind;
    int           rel;
    logic [127:0] content;
    string        tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [$bits(net_packet_s)-1:0] net_packet_flat;
  logic [$bits(mem_in_s)-1:0]     to_mem_flat;
  logic [31:0]                    data_mem_addr;
  logic                           mem_select;
  logic                           busy;
  logic                           done;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0]                    checksum;
`endif

  boot_loader_if #(.instr_count_p(N), .data_count_p(N), .reg_count_p(N)) rom_bus ();

  boot_loader #(.instr_count_p(N), .data_count_p(N), .reg_count_p(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .start_i           (start),
    .rom               (rom_bus.master),
    .net_packet_flat_o (net_packet_flat),
    .to_mem_flat_o     (to_mem_flat),
    .data_mem_addr_o   (data_mem_addr),
    .mem_select_o      (mem_select),
    .busy_o            (busy),
    .done_o            (done)
`ifdef BOOT_LOADER_CHECKSUM_EN
    ,
    .checksum_o        (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] instr_rom [N] = '{16'h1234, 16'hFFFF, 16'hA5C3, 16'h0001};
  logic [31:0] data_rom  [N] = '{32'h1000_0001, 32'hCAFE_BABE, 32'h0000_0000, 32'h8000_0000};
  logic [39:0] reg_rom   [N] = '{40'h25_DEADBEEF, 40'h03_00000010, 40'hC1_CAFEF00D, 40'h3F_FFFFFFFF};

  // Synchronous ROMs: data for an address appears the cycle after it is presented.
  always @(posedge clk) begin
    rom_bus.instr_rom_data_i <= instr_rom[rom_bus.instr_rom_addr_o];
    rom_bus.data_rom_data_i  <= data_rom[rom_bus.data_rom_addr_o];
    rom_bus.reg_rom_data_i   <= reg_rom[rom_bus.reg_rom_addr_o];
  end

  int cycle = 0;
  int start_cycle = 0;
  int checks = 0;
  int passes = 0;
  logic [31:0] exp_checksum = '0;
  exp_t exp_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  net_packet_s pkt;
  mem_in_s     mem;
  assign pkt = net_packet_flat;
  assign mem = to_mem_flat;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
  endtask

  function automatic logic [127:0] pkt_content(ev_kind_e k, logic [1:0] flags, logic [9:0] id,
                                               net_op_e op, logic [9:0] addr, logic [31:0] data);
    logic [127:0] r;
    r = '0;
    r[127:120] = 8'(k);
    r[56:0] = {flags, id, op, addr, data};
    return r;
  endfunction

  function automatic logic [127:0] store_content(logic [1:0] flags, logic [2:0] ctrl,
                                                 logic [31:0] addr, logic [31:0] data);
    logic [127:0] r;
    r = '0;
    r[127:120] = 8'(EV_STORE);
    r[68:0] = {flags, ctrl, addr, data};
    return r;
  endfunction

  function automatic void push_store(int rel, logic [31:0] addr, logic [31:0] data);
    exp_q.push_back('{EV_STORE, rel, store_content(2'b01, 3'b110, addr, data), $sformatf("store@%0h", addr)});
    exp_checksum += data;
  endfunction

  function automatic void push_pkt(int rel, net_op_e op, logic [9:0] addr, logic [31:0] data, string tag);
    exp_q.push_back('{EV_PKT, rel, pkt_content(EV_PKT, 2'b01, 10'd1, op, addr, data), tag});
    if (op == NET_OP_INSTR || op == NET_OP_REG) exp_checksum += data;
  endfunction

  // Issue a start pulse and queue the hand-derived boot sequence, timed in cycles after the start edge.
  task automatic applyStimulus();
    exp_checksum = '0;
    push_store(1, 32'd0,  32'h1000_0001);
    push_store(3, 32'd4,  32'hCAFE_BABE);
    push_store(5, 32'd8,  32'h0000_0000);
    push_store(7, 32'd12, 32'h8000_0000);
    push_pkt(9,  NET_OP_INSTR, 10'd0, 32'h0000_1234, "instr0");
    push_pkt(10, NET_OP_INSTR, 10'd1, 32'h0000_FFFF, "instr1");
    push_pkt(11, NET_OP_INSTR, 10'd2, 32'h0000_A5C3, "instr2");
    push_pkt(12, NET_OP_INSTR, 10'd3, 32'h0000_0001, "instr3");
    push_pkt(14, NET_OP_REG, 10'h25, 32'hDEAD_BEEF, "reg0");
    push_pkt(15, NET_OP_REG, 10'h03, 32'h0000_0010, "reg1");
    push_pkt(16, NET_OP_REG, 10'h01, 32'hCAFE_F00D, "reg2");
    push_pkt(17, NET_OP_REG, 10'h3F, 32'hFFFF_FFFF, "reg3");
    push_pkt(18, NET_OP_BAR, 10'd24, 32'h2, "bar");
    push_pkt(19, NET_OP_PC,  10'd0,  32'h5, "pc");
    exp_q.push_back('{EV_DONE, 20, pkt_content(EV_DONE, 2'b10, 10'd1, NET_OP_NULL, 10'd24, 32'hFFFF_FFFE), "done"});
    start = 1'b1;
    start_cycle = cycle + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    for (int i = 0; i < 200; i++) begin
      if (cycle - start_cycle == n) break;
      @(negedge clk);
    end
    checkOutput("wait_rel", 128'(cycle - start_cycle), 128'(n));
  endtask

  task automatic wait_done_and_drain(input string run);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    checkOutput({run, "_done_reached"}, 128'(done), 128'(1));
    repeat (3) @(negedge clk);
    checkOutput({run, "_queue_drained"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_packet"}, 128'(net_packet_flat), 128'(0));
    checkOutput({tag, "_to_mem"}, 128'(to_mem_flat), 128'(0));
    checkOutput({tag, "_mem_addr"}, 128'(data_mem_addr), 128'(0));
    checkOutput({tag, "_flags"}, 128'({mem_select, busy, done}), 128'(0));
    checkOutput({tag, "_rom_addrs"},
                128'({rom_bus.instr_rom_addr_o, rom_bus.data_rom_addr_o, rom_bus.reg_rom_addr_o}), 128'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  logic [127:0] obs;
  ev_kind_e     obs_kind;
  bit           have_obs;
  bit           done_seen = 1'b0;
  exp_t         cur;

  // Monitor: one observable event per cycle at most; each is matched against the head of the queue.
  always @(negedge clk) begin
    if (!reset) begin
      done_seen = 1'b0;
    end else begin
      have_obs = 1'b0;
      obs = '0;
      obs_kind = EV_STORE;
      if (mem.valid) begin
        have_obs = 1'b1;
        obs_kind = EV_STORE;
        obs = store_content({mem_select, busy}, {mem.wen, mem.yumi, mem.byte_not_word},
                            data_mem_addr, mem.write_data);
      end else if (pkt.net_op != NET_OP_NULL) begin
        have_obs = 1'b1;
        obs_kind = EV_PKT;
        obs = pkt_content(EV_PKT, {mem_select, busy}, pkt.id, pkt.net_op, pkt.net_addr, pkt.net_data);
      end else if (done && !done_seen) begin
        done_seen = 1'b1;
        have_obs = 1'b1;
        obs_kind = EV_DONE;
        obs = pkt_content(EV_DONE, {mem_select, busy}, pkt.id, pkt.net_op, pkt.net_addr, pkt.net_data);
`ifdef BOOT_LOADER_CHECKSUM_EN
        checkOutput("checksum", 128'(checksum), 128'(exp_checksum));
`endif
      end
      if (have_obs) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_event: actual kind=%0d content=%0h rel=%0d required=none",
                   obs_kind, obs, cycle - start_cycle);
        end else begin
          cur = exp_q.pop_front();
          checkOutput({cur.tag, "_timing"}, 128'(cycle - start_cycle), 128'(cur.rel));
          checkOutput({cur.tag, "_content"}, obs, cur.content);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] boot_loader bench start");
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("idle");

    // Plain boot.
    applyStimulus();
    wait_done_and_drain("runA");
    repeat (3) @(negedge clk);
    checkOutput("done_sticky", 128'({done, mem_select, busy}), 128'(3'b110));

    // A second start during INSTR must be ignored without disturbing timing.
    do_reset();
    applyStimulus();
    wait_rel(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done_and_drain("runB");

    // Reset during REG aborts; the block then waits for a fresh start and replays everything.
    do_reset();
    applyStimulus();
    wait_rel(15);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_values("abort");
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("abort_stays_idle", 128'({busy, done, mem_select}), 128'(0));
    applyStimulus();
    wait_done_and_drain("runC");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
